alu_issue_seq: RTL and testbench
================================

Name: alu_issue_seq

Overview:
- Operand-fetch and writeback sequencer that sits directly upstream of the ALU and feeds its L, R and OP inputs.
- Accepts one 16-bit instruction at a time over a valid/ready handshake and reads operands from an internal 8x16 register file.
- Waits out the ALU's one-cycle registered latency, then writes the ALU result back to the destination register.
- Strictly serialised: one instruction every 3 cycles, so no hazard logic is needed.

Parameters:
- NREG, 8, number of register-file entries. The address width is fixed at 3; NREG must be 8.
- DW, 16, datapath width. Must match the ALU's L, R and O width.

Ports:
- ck  in  1  clock; all state updates on posedge.
- res  in  1  reset; synchronous, active-low.
- instr  in  16  instruction word.
- instr_valid  in  1  instr is valid this cycle.
- instr_ready  out  1  block can accept an instruction; combinational, (state==IDLE) && res.
- alu_l  out  16  registered; drives ALU L.
- alu_r  out  16  registered; drives ALU R.
- alu_op  out  4  registered; drives ALU OP.
- alu_o  in  16  ALU result O.
- wb_valid  out  1  registered; one-cycle pulse when a register write occurs.
- wb_addr  out  3  registered; destination of the write.
- wb_data  out  16  registered; data written.
- illegal  out  1  registered; one-cycle pulse for an unsupported opcode.
- dbg_addr  in  3  debug read address.
- dbg_data  out  16  combinational read of rf[dbg_addr]; r0 reads 0.

Behaviour:
- Instruction format:
  - [15:12] op, [11:9] rd, [8:6] rs, [5:3] rt, [2:0] ignored.
  - LOADI uses imm = zero-extend(instr[7:0]).
- Supported op values are the define.v macros OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR and OP_LOADI. All other op values are illegal.
- Register r0 always reads 0. Writes to r0 are dropped: no rf update and no wb_valid.
- Reset (res==0 at a posedge):
  - state to IDLE.
  - All rf entries, alu_l, alu_r, alu_op, wb_valid, wb_addr, wb_data and illegal to 0.
  - instr_ready is 0 while res==0.
- FSM has three states: IDLE, EXEC, WB.
- IDLE:
  - A handshake occurs when instr_valid && instr_ready at a posedge.
  - At that edge: alu_l <= rf[rs]; alu_r <= (op==OP_LOADI) ? imm : rf[rt]; alu_op <= op; latch rd and op internally; go to EXEC.
  - Without a handshake, alu_* hold their values.
- EXEC (1 cycle):
  - alu_* held stable.
  - The ALU samples them at the closing edge. Go to WB.
- WB (1 cycle):
  - alu_o holds the result.
  - At the closing edge, if op is legal and rd!=0: rf[rd] <= alu_o; wb_valid <= 1; wb_addr <= rd; wb_data <= alu_o.
  - If op is illegal: illegal <= 1, no write.
  - Go to IDLE.
- wb_valid and illegal are high for exactly the one cycle following the WB edge; otherwise 0.
- Latency: handshake edge N, EXEC N+1, WB write at edge N+2. wb_valid is high during cycle N+2 to N+3. The next handshake is possible at edge N+3.
- Arithmetic is performed by the ALU, modulo 2^16. This block never inspects the result except to write it.
- Back-pressure: instr_valid may stay high through EXEC and WB. The instruction is not consumed until the IDLE handshake, and instr must be held stable by the source.
- Reset mid-operation (in EXEC or WB): abort, no rf write, no wb_valid, return to IDLE with all state cleared.
- Register-file read and write collision: reads occur only in IDLE and writes only in WB, so no bypass is needed.
- dbg_data reflects rf contents after the write edge.

Test Plan:
- Reset then LOADI r1,0x25 -> alu_op=OP_LOADI and alu_r=0x0025 at N+1; wb_valid pulse with wb_addr=1, wb_data=0x0025; dbg rf[1]=0x0025.
- LOADI r2,0x0F, then ADD r3,r1,r2 -> wb_data=0x0034; then SUB r4,r2,r1 -> wb_data=0xFFEA (wrap-around).
- AND/OR/XOR r5,r1,r2 -> results 0x0005, 0x002F, 0x002A written to r5 in turn. LOADI r0,0xFF -> no wb_valid, rf[0] reads 0.
- Hold instr_valid=1 for 6 cycles with two back-to-back instructions -> instr_ready high only in IDLE; exactly one handshake per 3 cycles; second instruction's wb_valid 3 cycles after the first.
- Illegal op (e.g. 4'hF) to rd=6 -> illegal pulse for 1 cycle, wb_valid=0, rf[6] unchanged.
- ADD r3,r1,r2 then res=0 during WB -> no write, wb_valid=0, all rf entries 0, instr_ready returns to 1 the cycle after res=1.

Source files
------------

// File: rtl/alu_issue_seq.sv
// Operand-fetch / writeback sequencer in front of a one-cycle registered ALU.
// One instruction is issued every three cycles (IDLE -> EXEC -> WB), so no hazard logic is needed.
module alu_issue_seq #(
    parameter int NREG = 8,
    parameter int DW   = 16
) (
    input  logic          ck,
    input  logic          res,
    input  logic [15:0]   instr,
    input  logic          instr_valid,
    output logic          instr_ready,
    output logic [DW-1:0] alu_l,
    output logic [DW-1:0] alu_r,
    output logic [3:0]    alu_op,
    input  logic [DW-1:0] alu_o,
    output logic          wb_valid,
    output logic [2:0]    wb_addr,
    output logic [DW-1:0] wb_data,
    output logic          illegal,
    input  logic [2:0]    dbg_addr,
    output logic [DW-1:0] dbg_data
);

    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_AND   = 4'h3;
    localparam logic [3:0] OP_OR    = 4'h4;
    localparam logic [3:0] OP_XOR   = 4'h5;
    localparam logic [3:0] OP_LOADI = 4'h6;

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   rf_q [NREG];
    logic [DW-1:0]   rf_d [NREG];
    logic [DW-1:0]   alu_l_q, alu_l_d;
    logic [DW-1:0]   alu_r_q, alu_r_d;
    logic [3:0]      alu_op_q, alu_op_d;
    logic [2:0]      rd_q, rd_d;
    logic [3:0]      op_q, op_d;
    logic            wb_valid_q, wb_valid_d;
    logic [2:0]      wb_addr_q, wb_addr_d;
    logic [DW-1:0]   wb_data_q, wb_data_d;
    logic            illegal_q, illegal_d;

    logic [3:0]      in_op;
    logic [2:0]      in_rd, in_rs, in_rt;
    logic [DW-1:0]   in_imm;

    function automatic logic op_legal(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_XOR) || (op == OP_LOADI);
    endfunction

    // r0 is hard-wired to zero regardless of the storage contents.
    function automatic logic [DW-1:0] rf_read(input logic [2:0] a);
        return (a == 3'd0) ? '0 : rf_q[a];
    endfunction

    assign in_op  = instr[15:12];
    assign in_rd  = instr[11:9];
    assign in_rs  = instr[8:6];
    assign in_rt  = instr[5:3];
    assign in_imm = {{(DW-8){1'b0}}, instr[7:0]};

    assign instr_ready = (state_q == IDLE) && res;
    assign dbg_data    = rf_read(dbg_addr);

    always_comb begin
        state_d    = state_q;
        rf_d       = rf_q;
        alu_l_d    = alu_l_q;
        alu_r_d    = alu_r_q;
        alu_op_d   = alu_op_q;
        rd_d       = rd_q;
        op_d       = op_q;
        wb_valid_d = 1'b0;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        illegal_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    alu_l_d  = rf_read(in_rs);
                    alu_r_d  = (in_op == OP_LOADI) ? in_imm : rf_read(in_rt);
                    alu_op_d = in_op;
                    rd_d     = in_rd;
                    op_d     = in_op;
                    state_d  = EXEC;
                end
            end
            EXEC: state_d = WB;
            WB: begin
                if (!op_legal(op_q)) begin
                    illegal_d = 1'b1;
                end else if (rd_q != 3'd0) begin
                    rf_d[rd_q] = alu_o;
                    wb_valid_d = 1'b1;
                    wb_addr_d  = rd_q;
                    wb_data_d  = alu_o;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset also aborts an in-flight instruction, so a WB-cycle reset drops the write.
    always_ff @(posedge ck) begin
        if (!res) begin
            state_q    <= IDLE;
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
            alu_l_q    <= '0;
            alu_r_q    <= '0;
            alu_op_q   <= '0;
            rd_q       <= '0;
            op_q       <= '0;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rf_q       <= rf_d;
            alu_l_q    <= alu_l_d;
            alu_r_q    <= alu_r_d;
            alu_op_q   <= alu_op_d;
            rd_q       <= rd_d;
            op_q       <= op_d;
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            illegal_q  <= illegal_d;
        end
    end

    assign alu_l    = alu_l_q;
    assign alu_r    = alu_r_q;
    assign alu_op   = alu_op_q;
    assign wb_valid = wb_valid_q;
    assign wb_addr  = wb_addr_q;
    assign wb_data  = wb_data_q;
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed bench for alu_issue_seq with a one-cycle registered ALU model attached.
module tb_alu_issue_seq;

    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_AND   = 4'h3;
    localparam logic [3:0] OP_OR    = 4'h4;
    localparam logic [3:0] OP_XOR   = 4'h5;
    localparam logic [3:0] OP_LOADI = 4'h6;

    logic        ck = 1'b0;
    logic        res = 1'b0;
    logic [15:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] alu_l, alu_r, alu_o;
    logic [3:0]  alu_op;
    logic        wb_valid, illegal;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic [2:0]  dbg_addr = '0;
    logic [15:0] dbg_data;

    int checks = 0;
    int errors = 0;

    alu_issue_seq #(.NREG(8), .DW(16)) dut (
        .ck(ck), .res(res), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .alu_l(alu_l), .alu_r(alu_r), .alu_op(alu_op),
        .alu_o(alu_o), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .illegal(illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 ck = ~ck;

    // Downstream ALU: result registered one cycle after L/R/OP are sampled.
    always_ff @(posedge ck) begin
        case (alu_op)
            OP_ADD:   alu_o <= alu_l + alu_r;
            OP_SUB:   alu_o <= alu_l - alu_r;
            OP_AND:   alu_o <= alu_l & alu_r;
            OP_OR:    alu_o <= alu_l | alu_r;
            OP_XOR:   alu_o <= alu_l ^ alu_r;
            OP_LOADI: alu_o <= alu_r;
            default:  alu_o <= 16'hDEAD;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_rf(input logic [2:0] a, input logic [15:0] exp);
        dbg_addr = a;
        #1;
        chk($sformatf("rf[%0d]", a), 32'(dbg_data), 32'(exp));
    endtask

    function automatic logic [15:0] rrr(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [2:0] rt);
        return {op, rd, rs, rt, 3'b000};
    endfunction

    function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [7:0] imm);
        return {OP_LOADI, rd, 1'b0, imm};
    endfunction

    // Issue one instruction and follow it through EXEC and WB, one negedge per cycle.
    task automatic run(input string tag, input logic [15:0] ins,
                       input logic [15:0] exp_l, input logic [15:0] exp_r,
                       input logic exp_wb, input logic [15:0] exp_data, input logic exp_ill);
        @(negedge ck);
        instr = ins;
        instr_valid = 1'b1;
        chk({tag, ".ready"}, 32'(instr_ready), 32'd1);
        @(negedge ck);
        instr_valid = 1'b0;
        chk({tag, ".alu_op"}, 32'(alu_op), 32'(ins[15:12]));
        chk({tag, ".alu_l"}, 32'(alu_l), 32'(exp_l));
        chk({tag, ".alu_r"}, 32'(alu_r), 32'(exp_r));
        chk({tag, ".busy"}, 32'(instr_ready), 32'd0);
        @(negedge ck);
        chk({tag, ".wb_early"}, 32'(wb_valid), 32'd0);
        @(negedge ck);
        chk({tag, ".wb_valid"}, 32'(wb_valid), 32'(exp_wb));
        chk({tag, ".illegal"}, 32'(illegal), 32'(exp_ill));
        if (exp_wb) begin
            chk({tag, ".wb_addr"}, 32'(wb_addr), 32'(ins[11:9]));
            chk({tag, ".wb_data"}, 32'(wb_data), 32'(exp_data));
        end
        @(negedge ck);
        chk({tag, ".wb_pulse"}, 32'(wb_valid), 32'd0);
        chk({tag, ".ill_pulse"}, 32'(illegal), 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge ck);
        chk("rst.ready", 32'(instr_ready), 32'd0);
        chk("rst.wb_valid", 32'(wb_valid), 32'd0);
        chk("rst.illegal", 32'(illegal), 32'd0);
        chk("rst.alu_op", 32'(alu_op), 32'd0);
        chk("rst.alu_l", 32'(alu_l), 32'd0);
        chk_rf(3'd1, 16'h0000);
        res = 1'b1;
        #1;
        chk("rst.ready_rel", 32'(instr_ready), 32'd1);

        // Main function
        run("ldi_r1", ldi(3'd1, 8'h25), 16'h0000, 16'h0025, 1'b1, 16'h0025, 1'b0);
        chk_rf(3'd1, 16'h0025);
        run("ldi_r2", ldi(3'd2, 8'h0F), 16'h0000, 16'h000F, 1'b1, 16'h000F, 1'b0);
        run("add_r3", rrr(OP_ADD, 3'd3, 3'd1, 3'd2), 16'h0025, 16'h000F, 1'b1, 16'h0034, 1'b0);
        run("sub_r4", rrr(OP_SUB, 3'd4, 3'd2, 3'd1), 16'h000F, 16'h0025, 1'b1, 16'hFFEA, 1'b0);
        chk_rf(3'd3, 16'h0034);
        chk_rf(3'd4, 16'hFFEA);
        run("and_r5", rrr(OP_AND, 3'd5, 3'd1, 3'd2), 16'h0025, 16'h000F, 1'b1, 16'h0005, 1'b0);
        chk_rf(3'd5, 16'h0005);
        run("or_r5", rrr(OP_OR, 3'd5, 3'd1, 3'd2), 16'h0025, 16'h000F, 1'b1, 16'h002F, 1'b0);
        chk_rf(3'd5, 16'h002F);
        run("xor_r5", rrr(OP_XOR, 3'd5, 3'd1, 3'd2), 16'h0025, 16'h000F, 1'b1, 16'h002A, 1'b0);
        chk_rf(3'd5, 16'h002A);
        // LOADI 0xFF puts 3'b011 in the rs field, so L reads r3.
        run("ldi_r0", ldi(3'd0, 8'hFF), 16'h0034, 16'h00FF, 1'b0, 16'h0000, 1'b0);
        chk_rf(3'd0, 16'h0000);

        // Illegal opcode
        run("ill_r6", rrr(4'hF, 3'd6, 3'd1, 3'd2), 16'h0025, 16'h000F, 1'b0, 16'h0000, 1'b1);
        chk_rf(3'd6, 16'h0000);

        // Back-to-back with instr_valid held for six cycles
        @(negedge ck);
        instr = rrr(OP_ADD, 3'd6, 3'd1, 3'd2);
        instr_valid = 1'b1;
        chk("b2b.rdy0", 32'(instr_ready), 32'd1);
        @(negedge ck);
        instr = rrr(OP_SUB, 3'd7, 3'd2, 3'd1);
        chk("b2b.rdy1", 32'(instr_ready), 32'd0);
        chk("b2b.l1", 32'(alu_l), 32'h0025);
        @(negedge ck);
        chk("b2b.rdy2", 32'(instr_ready), 32'd0);
        chk("b2b.wb2", 32'(wb_valid), 32'd0);
        @(negedge ck);
        chk("b2b.rdy3", 32'(instr_ready), 32'd1);
        chk("b2b.wb3", 32'(wb_valid), 32'd1);
        chk("b2b.addr3", 32'(wb_addr), 32'd6);
        chk("b2b.data3", 32'(wb_data), 32'h0034);
        @(negedge ck);
        chk("b2b.rdy4", 32'(instr_ready), 32'd0);
        chk("b2b.wb4", 32'(wb_valid), 32'd0);
        chk("b2b.l2", 32'(alu_l), 32'h000F);
        @(negedge ck);
        chk("b2b.rdy5", 32'(instr_ready), 32'd0);
        chk("b2b.wb5", 32'(wb_valid), 32'd0);
        @(negedge ck);
        instr_valid = 1'b0;
        chk("b2b.rdy6", 32'(instr_ready), 32'd1);
        chk("b2b.wb6", 32'(wb_valid), 32'd1);
        chk("b2b.addr6", 32'(wb_addr), 32'd7);
        chk("b2b.data6", 32'(wb_data), 32'hFFEA);
        @(negedge ck);
        chk("b2b.wb7", 32'(wb_valid), 32'd0);
        chk("b2b.rdy7", 32'(instr_ready), 32'd1);

        // Reset asserted during WB aborts the write
        @(negedge ck);
        instr = rrr(OP_ADD, 3'd3, 3'd1, 3'd2);
        instr_valid = 1'b1;
        @(negedge ck);
        instr_valid = 1'b0;
        @(negedge ck);
        res = 1'b0;
        @(negedge ck);
        chk("mid.wb_valid", 32'(wb_valid), 32'd0);
        chk("mid.ready", 32'(instr_ready), 32'd0);
        chk("mid.alu_l", 32'(alu_l), 32'd0);
        for (int a = 0; a < 8; a++) chk_rf(3'(a), 16'h0000);
        res = 1'b1;
        #1;
        chk("mid.ready_rel", 32'(instr_ready), 32'd1);
        @(negedge ck);
        chk("mid.wb_after", 32'(wb_valid), 32'd0);
        chk("mid.ready_idle", 32'(instr_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
